// File: rtl/pb_wire_decoder.sv
// Framed pipebomb wire-message decoder: 1 byte/cycle stream in, one parallel
// instruction beat out. Malformed frames are dropped whole and counted.
module pb_wire_decoder #(
   parameter int CNT_W   = 16,
   parameter bit FWD_NOP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tlast,
   output logic             m_v,
   input  logic             m_r,
   output logic [2:0]       m_opcode,
   output logic             m_valid,
   output logic [63:0]      m_timestamp,
   output logic             m_side,
   output logic [47:0]      m_order_id,
   output logic [47:0]      m_price,
   output logic [31:0]      m_quantity,
   output logic [47:0]      m_new_order_id,
   output logic             m_last_in_bundle,
   output logic [31:0]      msg_count,
   output logic [CNT_W-1:0] err_trunc,
   output logic [CNT_W-1:0] err_long,
   output logic [CNT_W-1:0] err_opcode
);

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_ADD     = 3'd1;
   localparam logic [2:0] OP_CANCEL  = 3'd2;
   localparam logic [2:0] OP_DELETE  = 3'd3;
   localparam logic [2:0] OP_REPLACE = 3'd4;
   localparam logic [2:0] OP_EXECUTE = 3'd5;

   typedef enum logic [1:0] {ST_HDR, ST_BODY, ST_DROP, ST_HOLD} state_t;

   function automatic logic [4:0] msg_len(input logic [2:0] op);
      case (op)
         OP_NOP:                msg_len = 5'd1;
         OP_DELETE:             msg_len = 5'd13;
         OP_CANCEL, OP_EXECUTE: msg_len = 5'd17;
         OP_ADD:                msg_len = 5'd23;
         OP_REPLACE:            msg_len = 5'd29;
         default:               msg_len = 5'd0;
      endcase
   endfunction

   state_t         state_reg, state_next;
   logic [4:0]     cnt_reg, len_reg;
   logic [5:0]     hdr_reg;     // header bits [7:2]
   logic [223:0]   asm_reg;     // body bytes, newest in [7:0]

   logic           accept, out_free, body_final;
   logic           complete, fwd, load;
   logic           inc_trunc, inc_long, inc_op;
   logic [5:0]     dec_hdr;
   logic [223:0]   body_full;
   logic [47:0]    dec_ts, dec_oid, dec_price, dec_nid;
   logic [31:0]    dec_qty;

   assign s_tready   = (state_reg != ST_HOLD) & ~rst;
   assign accept     = s_tvalid & s_tready;
   assign out_free   = ~m_v | m_r;
   assign body_final = (cnt_reg + 5'd1) == len_reg;
   // Held messages already own the whole body; live completions still need the final byte.
   assign body_full  = (state_reg == ST_HOLD) ? asm_reg : {asm_reg[215:0], s_tdata};
   assign dec_hdr    = (state_reg == ST_HDR) ? s_tdata[7:2] : hdr_reg;

   always_comb begin
      dec_ts    = '0;
      dec_oid   = '0;
      dec_price = '0;
      dec_nid   = '0;
      dec_qty   = '0;
      case (dec_hdr[5:3])
         OP_DELETE: begin
            dec_ts  = body_full[95:48];
            dec_oid = body_full[47:0];
         end
         OP_CANCEL, OP_EXECUTE: begin
            dec_ts  = body_full[127:80];
            dec_oid = body_full[79:32];
            dec_qty = body_full[31:0];
         end
         OP_ADD: begin
            dec_ts    = body_full[175:128];
            dec_oid   = body_full[127:80];
            dec_price = body_full[79:32];
            dec_qty   = body_full[31:0];
         end
         OP_REPLACE: begin
            dec_ts    = body_full[223:176];
            dec_oid   = body_full[175:128];
            dec_nid   = body_full[127:80];
            dec_price = body_full[79:32];
            dec_qty   = body_full[31:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      complete   = 1'b0;
      inc_trunc  = 1'b0;
      inc_long   = 1'b0;
      inc_op     = 1'b0;
      if (accept) begin
         case (state_reg)
            ST_HDR: begin
               if (s_tdata[7:5] > OP_EXECUTE) begin
                  inc_op     = 1'b1;
                  state_next = s_tlast ? ST_HDR : ST_DROP;
               end else if (s_tdata[7:5] == OP_NOP) begin
                  if (s_tlast) begin
                     complete = 1'b1;
                  end else begin
                     inc_long   = 1'b1;
                     state_next = ST_DROP;
                  end
               end else if (s_tlast) begin
                  inc_trunc = 1'b1;
               end else begin
                  state_next = ST_BODY;
               end
            end
            ST_BODY: begin
               if (body_final) begin
                  if (s_tlast) begin
                     complete = 1'b1;
                  end else begin
                     inc_long   = 1'b1;
                     state_next = ST_DROP;
                  end
               end else if (s_tlast) begin
                  inc_trunc  = 1'b1;
                  state_next = ST_HDR;
               end
            end
            ST_DROP: if (s_tlast) state_next = ST_HDR;
            default: ;
         endcase
      end
      fwd  = complete & ((dec_hdr[5:3] != OP_NOP) | FWD_NOP);
      load = (fwd & out_free) | ((state_reg == ST_HOLD) & ~m_v);
      if (complete)
         state_next = (fwd & ~out_free) ? ST_HOLD : ST_HDR;
      if ((state_reg == ST_HOLD) && !m_v)
         state_next = ST_HDR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_HDR;
         cnt_reg          <= '0;
         len_reg          <= '0;
         hdr_reg          <= '0;
         asm_reg          <= '0;
         m_v              <= 1'b0;
         m_opcode         <= '0;
         m_valid          <= 1'b0;
         m_timestamp      <= '0;
         m_side           <= 1'b0;
         m_order_id       <= '0;
         m_price          <= '0;
         m_quantity       <= '0;
         m_new_order_id   <= '0;
         m_last_in_bundle <= 1'b0;
         msg_count        <= '0;
         err_trunc        <= '0;
         err_long         <= '0;
         err_opcode       <= '0;
      end else begin
         state_reg <= state_next;
         if (accept && state_reg == ST_HDR) begin
            hdr_reg <= s_tdata[7:2];
            len_reg <= msg_len(s_tdata[7:5]);
            cnt_reg <= 5'd1;
            asm_reg <= '0;
         end else if (accept && state_reg == ST_BODY) begin
            cnt_reg <= cnt_reg + 5'd1;
            asm_reg <= body_full;
         end
         if (load) begin
            m_v              <= 1'b1;
            m_opcode         <= dec_hdr[5:3];
            m_side           <= dec_hdr[2];
            m_last_in_bundle <= dec_hdr[1];
            m_valid          <= dec_hdr[0];
            m_timestamp      <= {16'h0000, dec_ts};
            m_order_id       <= dec_oid;
            m_price          <= dec_price;
            m_quantity       <= dec_qty;
            m_new_order_id   <= dec_nid;
            msg_count        <= msg_count + 32'd1;
         end else if (m_r) begin
            m_v <= 1'b0;
         end
         if (inc_trunc && err_trunc != '1)   err_trunc  <= err_trunc + CNT_W'(1);
         if (inc_long && err_long != '1)     err_long   <= err_long + CNT_W'(1);
         if (inc_op && err_opcode != '1)     err_opcode <= err_opcode + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pb_wire_decoder.sv
// Bench for pb_wire_decoder: frames are built from message fields, and the
// expected beats and error counts come from frame-level rules.
module tb_pb_wire_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        m_v;
   logic        m_r = 1'b0;
   logic [2:0]  m_opcode;
   logic        m_valid;
   logic [63:0] m_timestamp;
   logic        m_side;
   logic [47:0] m_order_id, m_price, m_new_order_id;
   logic [31:0] m_quantity;
   logic        m_last_in_bundle;
   logic [31:0] msg_count;
   logic [15:0] err_trunc, err_long, err_opcode;

   always #5 clk = ~clk;

   pb_wire_decoder #(.CNT_W(16), .FWD_NOP(1'b1)) dut (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .s_tlast(s_tlast), .m_v(m_v), .m_r(m_r),
      .m_opcode(m_opcode), .m_valid(m_valid), .m_timestamp(m_timestamp),
      .m_side(m_side), .m_order_id(m_order_id), .m_price(m_price),
      .m_quantity(m_quantity), .m_new_order_id(m_new_order_id),
      .m_last_in_bundle(m_last_in_bundle), .msg_count(msg_count),
      .err_trunc(err_trunc), .err_long(err_long), .err_opcode(err_opcode));

   typedef struct packed {
      logic [2:0]  op;
      logic        valid;
      logic [63:0] ts;
      logic        side;
      logic [47:0] oid;
      logic [47:0] price;
      logic [31:0] qty;
      logic [47:0] nid;
      logic        lastb;
   } msg_t;
   typedef logic [7:0] bq_t[$];

   int   checks = 0;
   int   failures = 0;
   int   stall_cycles = 0;
   int   exp_msgs = 0, exp_trunc = 0, exp_long = 0, exp_op = 0;
   msg_t got_q[$];
   msg_t cur;

   always_comb begin
      cur.op    = m_opcode;
      cur.valid = m_valid;
      cur.ts    = m_timestamp;
      cur.side  = m_side;
      cur.oid   = m_order_id;
      cur.price = m_price;
      cur.qty   = m_quantity;
      cur.nid   = m_new_order_id;
      cur.lastb = m_last_in_bundle;
   end

   always @(negedge clk) if (!rst && m_v && m_r) got_q.push_back(cur);

   function automatic int len_of(input logic [2:0] op);
      case (op)
         3'd0: len_of = 1;
         3'd3: len_of = 13;
         3'd2, 3'd5: len_of = 17;
         3'd1: len_of = 23;
         3'd4: len_of = 29;
         default: len_of = 0;
      endcase
   endfunction

   function automatic msg_t rand_msg(input logic [2:0] op);
      msg_t m;
      m = '0;
      m.op = op;
      m.side = 1'($urandom);
      m.lastb = 1'($urandom);
      m.valid = 1'($urandom);
      if (op != 3'd0) begin
         m.ts  = {16'h0, 48'({$urandom(), $urandom()})};
         m.oid = 48'({$urandom(), $urandom()});
      end
      if (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) m.qty = $urandom();
      if (op == 3'd1 || op == 3'd4) m.price = 48'({$urandom(), $urandom()});
      if (op == 3'd4) m.nid = 48'({$urandom(), $urandom()});
      return m;
   endfunction

   function automatic bq_t frame_of(input msg_t m);
      bq_t q;
      q.push_back({m.op, m.side, m.lastb, m.valid, 2'($urandom)});
      if (m.op != 3'd0) begin
         for (int i = 5; i >= 0; i--) q.push_back(m.ts[i*8 +: 8]);
         for (int i = 5; i >= 0; i--) q.push_back(m.oid[i*8 +: 8]);
      end
      if (m.op == 3'd4) for (int i = 5; i >= 0; i--) q.push_back(m.nid[i*8 +: 8]);
      if (m.op == 3'd1 || m.op == 3'd4) for (int i = 5; i >= 0; i--) q.push_back(m.price[i*8 +: 8]);
      if (m.op == 3'd1 || m.op == 3'd2 || m.op == 3'd4 || m.op == 3'd5)
         for (int i = 3; i >= 0; i--) q.push_back(m.qty[i*8 +: 8]);
      return q;
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the last byte was accepted.
   task automatic send_bytes(input bq_t q, input bit with_last);
      int w;
      for (int i = 0; i < q.size(); i++) begin
         s_tdata  = q[i];
         s_tvalid = 1'b1;
         s_tlast  = with_last && (i == q.size() - 1);
         w = 0;
         @(negedge clk);
         while (!s_tready) begin
            stall_cycles++;
            w++;
            if (w > 500) begin
               checks++; failures++;
               $display("FAIL send_timeout: s_tready stuck at %0b for %0d cycles, required 1", s_tready, w);
               s_tvalid = 1'b0; s_tlast = 1'b0;
               return;
            end
            @(negedge clk);
         end
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; m_r = 1'b0; s_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready_in_rst: got %b want 0", s_tready); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (m_v !== 1'b0) begin failures++; $display("FAIL reset_m_v: got %b want 0", m_v); end
      checks++; if (cur !== '0) begin failures++; $display("FAIL reset_fields: got %h want 0", cur); end
      checks++; if (msg_count !== 32'd0) begin failures++; $display("FAIL reset_msg_count: got %0d want 0", msg_count); end
      checks++; if ({err_trunc, err_long, err_opcode} !== 48'd0) begin failures++;
         $display("FAIL reset_errs: got %h want 0", {err_trunc, err_long, err_opcode}); end
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_after: got %b want 1", s_tready); end
      exp_msgs = 0; exp_trunc = 0; exp_long = 0; exp_op = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_add();
      msg_t m;
      bq_t q, head, tail;
      m = '0; m.op = 3'd1; m.valid = 1'b1; m.lastb = 1'b1; m.side = 1'b0;
      m.ts = 64'h0102; m.oid = 48'h1234; m.price = 48'd1000000; m.qty = 32'd100;
      q = frame_of(m);
      for (int i = 0; i < 22; i++) head.push_back(q[i]);
      tail.push_back(q[22]);
      m_r = 1'b1; got_q.delete();
      send_bytes(head, 1'b0);
      @(negedge clk);
      checks++; if (m_v !== 1'b0) begin failures++; $display("FAIL add_early_m_v: got %b want 0", m_v); end
      @(posedge clk); #1;
      send_bytes(tail, 1'b1);
      @(negedge clk);
      checks++; if (m_v !== 1'b1) begin failures++; $display("FAIL add_latency_m_v: got %b want 1", m_v); end
      checks++; if (cur !== m) begin failures++; $display("FAIL add_fields: got %h want %h", cur, m); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (m_v !== 1'b0) begin failures++; $display("FAIL add_single_pulse: got %b want 0", m_v); end
      exp_msgs++;
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL add_msg_count: got %0d want %0d", msg_count, exp_msgs); end
      checks++; if (got_q.size() != 1) begin failures++; $display("FAIL add_beats: got %0d want 1", got_q.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      msg_t exp_q[$];
      msg_t m;
      m_r = 1'b1; got_q.delete(); stall_cycles = 0;
      for (int k = 0; k < 6; k++) begin
         m = rand_msg(3'(k));
         exp_q.push_back(m);
         send_bytes(frame_of(m), 1'b1);
      end
      repeat (3) @(posedge clk);
      #1;
      exp_msgs += 6;
      checks++; if (stall_cycles != 0) begin failures++; $display("FAIL b2b_stalls: got %0d want 0", stall_cycles); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL b2b_msg%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL b2b_msg_count: got %0d want %0d", msg_count, exp_msgs); end
   endtask

   task automatic test_stall_hold();
      msg_t a, d;
      int bad;
      a = rand_msg(3'd1); d = rand_msg(3'd3);
      m_r = 1'b0; got_q.delete();
      send_bytes(frame_of(a), 1'b1);
      send_bytes(frame_of(d), 1'b1);
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL hold_tready: got %b want 0", s_tready); end
      checks++; if (cur !== a) begin failures++; $display("FAIL hold_add_fields: got %h want %h", cur, a); end
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (cur !== a || m_v !== 1'b1 || s_tready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
      @(posedge clk); #1 m_r = 1'b1;
      @(negedge clk);
      checks++; if (cur !== a) begin failures++; $display("FAIL hold_drain_add: got %h want %h", cur, a); end
      @(negedge clk);
      checks++; if ({m_v, s_tready} !== 2'b00) begin failures++; $display("FAIL hold_bubble: got m_v,tready=%b want 00", {m_v, s_tready}); end
      @(negedge clk);
      checks++; if ({m_v, s_tready} !== 2'b11) begin failures++; $display("FAIL hold_release: got m_v,tready=%b want 11", {m_v, s_tready}); end
      checks++; if (cur !== d) begin failures++; $display("FAIL hold_delete_fields: got %h want %h", cur, d); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_msgs += 2;
      checks++; if (got_q.size() != 2 || got_q[0] !== a || got_q[1] !== d) begin failures++;
         $display("FAIL hold_order: got %0d beats want 2 (ADD then DELETE)", got_q.size()); end
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL hold_msg_count: got %0d want %0d", msg_count, exp_msgs); end
   endtask

   task automatic test_trunc();
      msg_t c, e;
      bq_t q, part;
      c = rand_msg(3'd2); q = frame_of(c);
      for (int i = 0; i < 10; i++) part.push_back(q[i]);
      m_r = 1'b1; got_q.delete();
      send_bytes(part, 1'b1);
      exp_trunc++;
      @(negedge clk);
      checks++; if (err_trunc !== 16'(exp_trunc)) begin failures++; $display("FAIL trunc_count: got %0d want %0d", err_trunc, exp_trunc); end
      checks++; if (m_v !== 1'b0) begin failures++; $display("FAIL trunc_no_output: got %b want 0", m_v); end
      @(posedge clk); #1;
      e = rand_msg(3'd5); e.qty = 32'd7;
      send_bytes(frame_of(e), 1'b1);
      @(negedge clk);
      exp_msgs++;
      checks++; if (m_v !== 1'b1 || cur !== e) begin failures++; $display("FAIL trunc_next_exec: got v=%b %h want v=1 %h", m_v, cur, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_long();
      msg_t d, n;
      bq_t q;
      d = rand_msg(3'd3); q = frame_of(d);
      q.push_back(8'($urandom)); q.push_back(8'($urandom));
      got_q.delete();
      send_bytes(q, 1'b1);
      exp_long++;
      @(negedge clk);
      checks++; if (err_long !== 16'(exp_long)) begin failures++; $display("FAIL long_count: got %0d want %0d", err_long, exp_long); end
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL long_no_output: got %0d beats want 0", got_q.size()); end
      @(posedge clk); #1;
      n = rand_msg(3'd4);
      send_bytes(frame_of(n), 1'b1);
      @(negedge clk);
      exp_msgs++;
      checks++; if (m_v !== 1'b1 || cur !== n) begin failures++; $display("FAIL long_next_frame: got v=%b %h want v=1 %h", m_v, cur, n); end
      @(posedge clk); #1;
   endtask

   task automatic test_bad_opcode();
      msg_t prev;
      bq_t q;
      prev = cur;
      q.push_back({3'd7, 5'($urandom)});
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      got_q.delete();
      send_bytes(q, 1'b1);
      exp_op++;
      @(negedge clk);
      checks++; if (err_opcode !== 16'(exp_op)) begin failures++; $display("FAIL badop_count: got %0d want %0d", err_opcode, exp_op); end
      repeat (2) @(negedge clk);
      checks++; if (got_q.size() != 0 || m_v !== 1'b0) begin failures++; $display("FAIL badop_no_output: got %0d beats want 0", got_q.size()); end
      checks++; if (cur !== prev) begin failures++; $display("FAIL badop_fields_leak: got %h want %h", cur, prev); end
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL badop_msg_count: got %0d want %0d", msg_count, exp_msgs); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      msg_t r, r2;
      bq_t q, part;
      r = rand_msg(3'd4); q = frame_of(r);
      for (int i = 0; i < 12; i++) part.push_back(q[i]);
      send_bytes(part, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rstmid_tready: got %b want 0", s_tready); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if ({m_v, cur, msg_count, err_trunc, err_long, err_opcode} !== '0) begin failures++;
         $display("FAIL rstmid_outputs: got v=%b %h cnt=%0d want all 0", m_v, cur, msg_count); end
      exp_msgs = 0; exp_trunc = 0; exp_long = 0; exp_op = 0;
      @(posedge clk); #1;
      r2 = rand_msg(3'd4); r2.nid = 48'hABCD; r2.price = 48'd42; r2.qty = 32'd9;
      send_bytes(frame_of(r2), 1'b1);
      @(negedge clk);
      exp_msgs++;
      checks++; if (m_v !== 1'b1 || cur !== r2) begin failures++; $display("FAIL rstmid_replace: got v=%b %h want v=1 %h", m_v, cur, r2); end
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL rstmid_msg_count: got %0d want %0d", msg_count, exp_msgs); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      msg_t exp_q[$];
      msg_t m;
      bq_t q, part;
      bit drv_done;
      int kind, l, n, w;
      logic [2:0] op;
      drv_done = 1'b0; got_q.delete();
      fork
         begin
            for (int f = 0; f < 150; f++) begin
               kind = $urandom_range(0, 9);
               part.delete();
               if (kind <= 5 || kind == 9) begin
                  m = rand_msg(3'($urandom_range(0, 5)));
                  exp_q.push_back(m); exp_msgs++;
                  send_bytes(frame_of(m), 1'b1);
               end else if (kind == 6) begin
                  op = 3'($urandom_range(1, 5));
                  q = frame_of(rand_msg(op));
                  l = $urandom_range(1, len_of(op) - 1);
                  for (int i = 0; i < l; i++) part.push_back(q[i]);
                  exp_trunc++;
                  send_bytes(part, 1'b1);
               end else if (kind == 7) begin
                  q = frame_of(rand_msg(3'($urandom_range(0, 5))));
                  n = $urandom_range(1, 3);
                  for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                  exp_long++;
                  send_bytes(q, 1'b1);
               end else begin
                  part.push_back({3'($urandom_range(6, 7)), 5'($urandom)});
                  n = $urandom_range(0, 5);
                  for (int i = 0; i < n; i++) part.push_back(8'($urandom));
                  exp_op++;
                  send_bytes(part, 1'b1);
               end
               if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               m_r = 1'($urandom);
            end
         end
      join
      m_r = 1'b1;
      w = 0;
      while (got_q.size() < exp_q.size() && w < 200) begin @(posedge clk); #1; w++; end
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL rand_msg%0d: got %h want %h", k, got_q[k], exp_q[k]); end
      end
      checks++; if (msg_count !== 32'(exp_msgs)) begin failures++; $display("FAIL rand_msg_count: got %0d want %0d", msg_count, exp_msgs); end
      checks++; if (err_trunc !== 16'(exp_trunc)) begin failures++; $display("FAIL rand_err_trunc: got %0d want %0d", err_trunc, exp_trunc); end
      checks++; if (err_long !== 16'(exp_long)) begin failures++; $display("FAIL rand_err_long: got %0d want %0d", err_long, exp_long); end
      checks++; if (err_opcode !== 16'(exp_op)) begin failures++; $display("FAIL rand_err_opcode: got %0d want %0d", err_opcode, exp_op); end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_stall_hold();
      test_trunc();
      test_long();
      test_bad_opcode();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pb_wire_decoder.md
# pb_wire_decoder

Byte-stream decoder that turns framed pipebomb wire messages into the parallel instruction beat consumed by `pipebomb_top`'s `s_*` port group. It sits between the feed ingress (one message per AXI-Stream-style frame, 1 byte/cycle) and the top-level message FIFO. It assembles fields big-endian, validates length and opcode, and counts errors. Malformed frames are dropped whole.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating error counters.
- `FWD_NOP`, 1: 1 forwards NOP messages; 0 silently consumes them.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_tdata`  in  8  stream byte.
- `s_tvalid`  in  1  byte valid.
- `s_tready`  out  1  byte accepted when `s_tvalid & s_tready`.
- `s_tlast`  in  1  last byte of frame.
- `m_v`  out  1  instruction valid.
- `m_r`  in  1  downstream ready; connects to `pipebomb_top.s_r`.
- `m_opcode`  out  3  opcode_t.
- `m_valid`  out  1  header valid bit.
- `m_timestamp`  out  64  timestamp, zero-extended from 48.
- `m_side`  out  1  0=bid, 1=ask.
- `m_order_id`  out  48  order id.
- `m_price`  out  48  price.
- `m_quantity`  out  32  quantity.
- `m_new_order_id`  out  48  replacement id.
- `m_last_in_bundle`  out  1  bundle terminator.
- `msg_count`  out  32  messages emitted (wraps).
- `err_trunc`  out  CNT_W  frames ended early (saturating).
- `err_long`  out  CNT_W  frames too long (saturating).
- `err_opcode`  out  CNT_W  unknown opcodes (saturating).

## Operation
- Header byte layout: [7:5] opcode, [4] side, [3] last_in_bundle, [2] valid, [1:0] ignored.
- Opcodes: NOP=0, ADD=1, CANCEL=2, DELETE=3, REPLACE=4, EXECUTE=5. Codes 6 and 7 are unknown.
- Body follows the header, big-endian, in order: ts(6), order_id(6), then per-opcode fields.
- Total message lengths:
  - NOP = 1 (header only).
  - DELETE = 13.
  - CANCEL / EXECUTE = 17 (+ qty(4)).
  - ADD = 23 (+ price(6), qty(4)).
  - REPLACE = 29 (+ new_order_id(6), price(6), qty(4)).
- Fields absent for an opcode are driven as 0.
- The byte counter is 5 bits. The expected length is latched from the header.
- State machine:
  - HDR:
    - Accept header.
    - Unknown opcode: `err_opcode`++. Go to HDR if `s_tlast`, else DROP.
    - NOP with `s_tlast`: complete. NOP without `s_tlast`: `err_long`++, go to DROP.
    - Any other opcode with `s_tlast`: `err_trunc`++, stay in HDR. Otherwise go to BODY.
  - BODY:
    - Shift bytes into the assembly register.
    - `s_tlast` before the final byte: `err_trunc`++, discard, go to HDR.
    - Final byte without `s_tlast`: `err_long`++, go to DROP.
    - Final byte with `s_tlast`: complete.
  - DROP: accept and discard bytes until `s_tlast`, then go to HDR.
  - HOLD: message assembled but the output register is occupied. `s_tready`=0. On the first cycle the output register is free, load it and go to HDR.
- Completion: if the output register is empty or draining this cycle (`!m_v | m_r`), load it and go to HDR. Otherwise go to HOLD.
- `s_tready` is 1 in HDR, BODY and DROP; 0 in HOLD and while `rst` is asserted. It must not depend combinationally on `m_r`.
- Output register: `m_v` sets on load and clears on `m_v & m_r` unless reloaded in the same cycle. Fields are stable while `m_v & !m_r`.
- `msg_count` increments on each load. With `FWD_NOP`=0, a completed NOP is not loaded and not counted.
- Error counters saturate at all-ones.

## Timing
- Reset: `m_v`=0, all `m_*` fields 0, all counters 0, state HDR, assembly and output registers cleared.
- Reset mid-frame discards the partial message. The first byte after reset is treated as a header.
- Latency: final byte accepted at cycle t → `m_v`=1 at t+1.
- Throughput: 1 byte/cycle sustained with `m_r`=1. No bubble between frames.
- Stall: while `m_v & !m_r`, the next frame may fully assemble. Its final byte is accepted, then the block enters HOLD.
- Release from HOLD: the cycle with `m_r`=1 drains the current message. The held message appears on the next cycle (one bubble). `s_tready` returns to 1 that same next cycle.
- Simultaneous drain and load on the same cycle: `m_v` stays 1 with the new fields.
- Error counters update in the cycle after the offending byte.

## Test plan
- ADD, bid, valid=1, last=1; ts=0x0000_0000_0102, id=0x1234, price=1000000, qty=100; `m_r`=1 → one `m_v` pulse 1 cycle after byte 23 with exactly these fields; `m_new_order_id`=0; `msg_count`=1.
- ADD then DELETE back-to-back with `m_r`=0 for 40 cycles → ADD held stable; DELETE's 13th byte accepted, then `s_tready`=0. After `m_r`=1: ADD, bubble, DELETE, in that order. `msg_count`=2.
- CANCEL with `s_tlast` on byte 10 → no `m_v`, `err_trunc`=1. A following EXECUTE (qty=7) decodes correctly.
- DELETE frame of 15 bytes → no `m_v`, `err_long`=1. Bytes 14-15 discarded. The next frame's header is parsed correctly.
- Header opcode 7 with a 5-byte frame → `err_opcode`=1, no output. 0x.. bytes of that frame never reach `m_*`.
- `rst` pulsed at REPLACE byte 12 → all outputs 0. A complete REPLACE (new id=0xABCD, price=42, qty=9) afterwards decodes correctly.
